seq_mult_unit: RTL and testbench



---
 rtl/seq_mult_unit.sv | 142 ++++++++++++++
 tb/tb_seq_mult_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// -----------------------------------------------------------------------------
// seq_mult_unit
//   Iterative shift-add multiplier with optional two's-complement operation,
//   valid/ready handshakes on both sides and early termination once the
//   remaining multiplier bits are all zero.
//
//   Signed operands are converted to magnitudes when they are accepted. The
//   magnitudes are multiplied unsigned, and the product is negated at the end
//   if the operand signs differed. A magnitude of 2^(WIDTH-1) is still exact
//   when read as an unsigned WIDTH-bit value.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   in_valid     operands presented
//   in_ready     block can accept operands (IDLE only)
//   signed_mode  1 = two's-complement operands, sampled on the accept edge
//   multiplicand operand A
//   multiplier   operand B; its magnitude sets the iteration count
//   out_valid    product valid (DONE)
//   out_ready    consumer accepts the product
//   product      2*WIDTH-bit result
//   iter_count   iterations used by the last completed operation
//   busy         high in RUN or DONE
// -----------------------------------------------------------------------------
module seq_mult_unit #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [CW-1:0]        iter_count,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        iter_q, iter_d;

  // Operand magnitudes. The most negative value negates to itself, and that
  // bit pattern read as unsigned is exactly the magnitude we want.
  logic [WIDTH-1:0]     abs_a, abs_b;
  assign abs_a = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign abs_b = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;

  // One RUN iteration: the conditional add plus the shifted state that follows it.
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_shr;
  logic [CW-1:0]        cnt_inc;
  logic                 last_iter;
  assign acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shr = mplier_q >> 1;
  assign cnt_inc    = cnt_q + CW'(1);
  // Stop once no set multiplier bits remain. This gives max(1, bitlen(|B|))
  // iterations. The WIDTH bound is a backstop for the full-length case.
  assign last_iter  = (mplier_shr == '0) || (cnt_inc == CW'(WIDTH));

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    iter_d    = iter_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_shr;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_inc;
        if (last_iter) begin
          // The product includes this cycle's add; the sign is applied here.
          product_d = sign_q ? -acc_sum : acc_sum;
          iter_d    = cnt_inc;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      iter_q    <= iter_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign product    = product_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int vec_cnt = 0;
  int err_cnt = 0;

  // 8-bit instance
  logic        in_valid8 = 1'b0, in_ready8, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        out_valid8, out_ready8 = 1'b0, busy8;
  logic [15:0] prod8;
  logic [3:0]  iter8;

  seq_mult_unit #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(prod8), .iter_count(iter8), .busy(busy8)
  );

  // Default-width instance
  logic        in_valid27 = 1'b0, in_ready27, sm27 = 1'b0;
  logic [26:0] a27 = '0, b27 = '0;
  logic        out_valid27, out_ready27 = 1'b0, busy27;
  logic [53:0] prod27;
  logic [4:0]  iter27;

  seq_mult_unit u27 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid27), .in_ready(in_ready27), .signed_mode(sm27),
    .multiplicand(a27), .multiplier(b27),
    .out_valid(out_valid27), .out_ready(out_ready27),
    .product(prod27), .iter_count(iter27), .busy(busy27)
  );

  // Reference: a plain 64-bit multiply of the sign/zero-extended operands.
  function automatic logic [53:0] ref_prod(input logic [26:0] a, input logic [26:0] b, input logic sm);
    longint sa, sb, p;
    sa = sm ? {{37{a[26]}}, a} : {37'd0, a};
    sb = sm ? {{37{b[26]}}, b} : {37'd0, b};
    p  = sa * sb;
    return p[53:0];
  endfunction

  function automatic int ref_iter(input logic [26:0] b, input logic sm);
    logic [26:0] mag;
    int n;
    mag = (sm && b[26]) ? -b : b;
    n = 0;
    for (int i = 0; i < 27; i++) if (mag[i]) n = i + 1;
    return (n == 0) ? 1 : n;
  endfunction

  // Present one operation, count edges from accept until out_valid, then consume.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         output logic [15:0] p, output logic [3:0] it, output int lat);
    @(negedge clock);
    a8 = a; b8 = b; sm8 = sm; in_valid8 = 1'b1;
    @(negedge clock);
    lat = 1;
    in_valid8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
    while (!out_valid8 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    p = prod8; it = iter8;
    out_ready8 = 1'b1;
    @(negedge clock);
    out_ready8 = 1'b0;
  endtask

  task automatic run_op27(input logic [26:0] a, input logic [26:0] b, input logic sm,
                          output logic [53:0] p, output logic [4:0] it, output int lat);
    @(negedge clock);
    a27 = a; b27 = b; sm27 = sm; in_valid27 = 1'b1;
    @(negedge clock);
    lat = 1;
    in_valid27 = 1'b0; a27 = ~a; b27 = ~b;
    while (!out_valid27 && lat < 64) begin
      @(negedge clock);
      lat++;
    end
    p = prod27; it = iter27;
    out_ready27 = 1'b1;
    @(negedge clock);
    out_ready27 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    vec_cnt += 6;
    if (in_ready8 !== 1'b1) begin err_cnt++; $display("FAIL rst_in_ready: got %b expected 1", in_ready8); end
    if (out_valid8 !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %b expected 0", out_valid8); end
    if (busy8 !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b expected 0", busy8); end
    if (prod8 !== 16'h0) begin err_cnt++; $display("FAIL rst_product: got %h expected 0000", prod8); end
    if (iter8 !== 4'h0) begin err_cnt++; $display("FAIL rst_iter: got %0d expected 0", iter8); end
    if (in_ready27 !== 1'b1 || out_valid27 !== 1'b0 || prod27 !== 54'h0) begin
      err_cnt++; $display("FAIL rst_w27: got rdy=%b vld=%b prod=%h expected 1 0 0", in_ready27, out_valid27, prod27);
    end
    @(negedge clock);
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_ops8(input string name, input int n,
                           input logic [7:0] va [8], input logic [7:0] vb [8], input logic vs [8],
                           input logic [15:0] vp [8], input int vi [8]);
    logic [15:0] p; logic [3:0] it; int lat;
    for (int k = 0; k < n; k++) begin
      run_op8(va[k], vb[k], vs[k], p, it, lat);
      vec_cnt += 4;
      if (p !== vp[k]) begin err_cnt++; $display("FAIL %s_prod[%0d]: got %h expected %h", name, k, p, vp[k]); end
      if (it !== vi[k][3:0]) begin err_cnt++; $display("FAIL %s_iter[%0d]: got %0d expected %0d", name, k, it, vi[k]); end
      if (lat != vi[k] + 1) begin err_cnt++; $display("FAIL %s_latency[%0d]: got %0d expected %0d", name, k, lat, vi[k] + 1); end
      if (in_ready8 !== 1'b1) begin err_cnt++; $display("FAIL %s_idle[%0d]: got in_ready %b expected 1", name, k, in_ready8); end
      $display("%s op %0d: %h x %h signed=%b -> %h iter=%0d latency=%0d", name, k, va[k], vb[k], vs[k], p, it, lat);
    end
  endtask

  task automatic test_unsigned8();
    logic [7:0] va [8], vb [8]; logic vs [8]; logic [15:0] vp [8]; int vi [8];
    va = '{8'hFF, 8'h7F, 8'h0D, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    vb = '{8'hFF, 8'h00, 8'h0B, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vp = '{16'hFE01, 16'h0000, 16'h008F, 16'h0080, 16'h0, 16'h0, 16'h0, 16'h0};
    vi = '{8, 1, 4, 8, 0, 0, 0, 0};
    test_ops8("uns8", 4, va, vb, vs, vp, vi);
  endtask

  task automatic test_signed8();
    logic [7:0] va [8], vb [8]; logic vs [8]; logic [15:0] vp [8]; int vi [8];
    va = '{8'h80, 8'h80, 8'h05, 8'h00, 8'h7F, 8'hFF, 8'hFD, 8'h00};
    vb = '{8'h80, 8'h01, 8'hFD, 8'hFB, 8'h7F, 8'hFF, 8'h02, 8'h00};
    vs = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vp = '{16'h4000, 16'hFF80, 16'hFFF1, 16'h0000, 16'h3F01, 16'h0001, 16'hFFFA, 16'h0};
    vi = '{8, 1, 2, 3, 7, 1, 2, 0};
    test_ops8("sgn8", 7, va, vb, vs, vp, vi);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clock);
    a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clock);
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 64) begin @(negedge clock); lat++; end
    vec_cnt++;
    if (lat != 7) begin err_cnt++; $display("FAIL bp_latency: got %0d expected 7", lat); end
    for (int i = 0; i < 5; i++) begin
      in_valid8 = (i % 2 == 0); a8 = 8'h55; b8 = 8'h66;
      @(negedge clock);
      vec_cnt += 4;
      if (out_valid8 !== 1'b1) begin err_cnt++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, out_valid8); end
      if (prod8 !== 16'h03A8) begin err_cnt++; $display("FAIL bp_prod[%0d]: got %h expected 03a8", i, prod8); end
      if (iter8 !== 4'd6) begin err_cnt++; $display("FAIL bp_iter[%0d]: got %0d expected 6", i, iter8); end
      if (in_ready8 !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready8); end
      $display("bp hold %0d: valid=%b prod=%h in_ready=%b", i, out_valid8, prod8, in_ready8);
    end
    // Consume with operands still offered: they must not be taken on this edge.
    in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(negedge clock);
    out_ready8 = 1'b0;
    vec_cnt += 3;
    if (out_valid8 !== 1'b0) begin err_cnt++; $display("FAIL bp_release_valid: got %b expected 0", out_valid8); end
    if (in_ready8 !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready: got %b expected 1", in_ready8); end
    if (busy8 !== 1'b0) begin err_cnt++; $display("FAIL bp_no_same_edge_accept: got busy %b expected 0", busy8); end
    in_valid8 = 1'b0;
    $display("bp release: valid=%b in_ready=%b busy=%b", out_valid8, in_ready8, busy8);
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] p; logic [3:0] it; int lat; logic saw_valid;
    @(negedge clock);
    a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clock);
    #1 in_valid8 = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    vec_cnt += 5;
    if (out_valid8 !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid8); end
    if (in_ready8 !== 1'b1) begin err_cnt++; $display("FAIL mid_rst_ready: got %b expected 1", in_ready8); end
    if (busy8 !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_busy: got %b expected 0", busy8); end
    if (prod8 !== 16'h0) begin err_cnt++; $display("FAIL mid_rst_prod: got %h expected 0000", prod8); end
    if (iter8 !== 4'h0) begin err_cnt++; $display("FAIL mid_rst_iter: got %0d expected 0", iter8); end
    @(negedge clock);
    reset = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin @(negedge clock); if (out_valid8 !== 1'b0) saw_valid = 1'b1; end
    vec_cnt++;
    if (saw_valid) begin err_cnt++; $display("FAIL mid_rst_no_output: got out_valid after abort expected none"); end
    run_op8(8'h03, 8'h04, 1'b0, p, it, lat);
    vec_cnt += 3;
    if (p !== 16'd12) begin err_cnt++; $display("FAIL post_rst_prod: got %h expected 000c", p); end
    if (it !== 4'd3) begin err_cnt++; $display("FAIL post_rst_iter: got %0d expected 3", it); end
    if (lat != 4) begin err_cnt++; $display("FAIL post_rst_latency: got %0d expected 4", lat); end
    $display("reset mid-run then 3x4 -> %h iter=%0d latency=%0d", p, it, lat);
  endtask

  task automatic test_wide27();
    logic [26:0] va [16], vb [16]; logic vs [16];
    logic [53:0] p, exp_p; logic [4:0] it; int lat, exp_i;
    va = '{27'h0, 27'h1, 27'h7FFFFFF, 27'h7FFFFFF, 27'h4000000, 27'h4000000, 27'h1, 27'h7FFFFFF,
           27'h0, 27'h0003039, 27'h0, 27'h0, 27'h0, 27'h0, 27'h0, 27'h0};
    vb = '{27'h0, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 27'h4000000, 27'h1, 27'h4000000, 27'h4000000,
           27'h7FFFFFF, 27'h4000001, 27'h0, 27'h0, 27'h0, 27'h0, 27'h0, 27'h0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 10; k < 16; k++) begin
      va[k] = 27'($urandom);
      vb[k] = 27'($urandom) >> $urandom_range(0, 26);
      vs[k] = 1'($urandom);
    end
    for (int k = 0; k < 16; k++) begin
      run_op27(va[k], vb[k], vs[k], p, it, lat);
      exp_p = ref_prod(va[k], vb[k], vs[k]);
      exp_i = ref_iter(vb[k], vs[k]);
      vec_cnt += 3;
      if (p !== exp_p) begin err_cnt++; $display("FAIL w27_prod[%0d]: got %h expected %h", k, p, exp_p); end
      if (it !== exp_i[4:0]) begin err_cnt++; $display("FAIL w27_iter[%0d]: got %0d expected %0d", k, it, exp_i); end
      if (lat != exp_i + 1) begin err_cnt++; $display("FAIL w27_latency[%0d]: got %0d expected %0d", k, lat, exp_i + 1); end
      $display("w27 op %0d: %h x %h signed=%b -> %h iter=%0d", k, va[k], vb[k], vs[k], p, it);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned8();
    test_signed8();
    test_backpressure();
    test_reset_mid_run();
    test_wide27();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
